// File: rtl/mdu_issue_ctrl.sv
// Issue/hazard controller between the E-stage and the multiply/divide unit.
// Optional build macro MDU_DIV0_GUARD_EN: suppresses divide-by-zero issue and adds div0_flag.
module mdu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic        flush,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic [2:0]  mdu_op,
  output logic        mdu_start,
  output logic [31:0] mdu_d1,
  output logic [31:0] mdu_d2,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        ctrl_busy,
`ifdef MDU_DIV0_GUARD_EN
  output logic        div0_flag,
`endif
  output logic        timeout_err
);

  // mflo shares code 0 with MDU_NONE: mfhi/mflo are never forwarded to the MDU.
  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;
  localparam logic [2:0] MDU_MFHI  = 3'd7;
  localparam logic [2:0] MDU_MFLO  = 3'd0;

  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e         state_q, state_d;
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d, wd_inc;
  logic           ctrl_busy_q, ctrl_busy_d;
  logic           timeout_err_q, timeout_err_d;

  logic occupied, issue, is_muldiv, is_mt, div0_block;

  always_comb begin
    is_muldiv = (req_op == MDU_MULT) || (req_op == MDU_MULTU) ||
                (req_op == MDU_DIV)  || (req_op == MDU_DIVU);
    is_mt     = (req_op == MDU_MTHI) || (req_op == MDU_MTLO);
    occupied  = (state_q != StIdle) || mdu_busy;
    stall     = req_valid && !flush && occupied;
    issue     = req_valid && !flush && !occupied;
`ifdef MDU_DIV0_GUARD_EN
    div0_block = ((req_op == MDU_DIV) || (req_op == MDU_DIVU)) && (rt_data == 32'd0);
`else
    div0_block = 1'b0;
`endif
    mdu_start = issue && is_muldiv && !div0_block;
    mdu_op    = (mdu_start || (issue && is_mt)) ? req_op : MDU_NONE;
    mdu_d1    = rs_data;
    mdu_d2    = (req_op == MDU_MTLO) ? rs_data : rt_data;
    rd_data   = 32'd0;
    if (issue && (req_op == MDU_MFHI)) rd_data = mdu_hi;
    if (issue && (req_op == MDU_MFLO)) rd_data = mdu_lo;
  end

  always_comb begin
    state_d       = state_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    wd_inc        = wd_cnt_q + WdW'(1);
    unique case (state_q)
      StIdle: begin
        if (mdu_start) begin
          state_d  = StLaunch;
          wd_cnt_d = '0;
        end
      end
      // One cycle of grace so the MDU's Busy has time to rise.
      StLaunch: begin
        state_d  = StWait;
        wd_cnt_d = wd_inc;
      end
      StWait: begin
        wd_cnt_d = wd_inc;
        if (!mdu_busy) begin
          state_d = StIdle;
        end else if (wd_inc == WdLimit) begin
          state_d       = StIdle;
          timeout_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    ctrl_busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      wd_cnt_q      <= '0;
      ctrl_busy_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_cnt_q      <= wd_cnt_d;
      ctrl_busy_q   <= ctrl_busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef MDU_DIV0_GUARD_EN
  logic div0_flag_q, div0_flag_d;

  always_comb begin
    div0_flag_d = div0_flag_q || (issue && div0_block);
  end

  always_ff @(posedge clk) begin
    if (reset) div0_flag_q <= 1'b0;
    else       div0_flag_q <= div0_flag_d;
  end

  assign div0_flag = div0_flag_q;
`endif

  assign ctrl_busy   = ctrl_busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: behavioural MDU, architectural HI/LO model, random program.
module tb_mdu_issue_ctrl;

  localparam int TO = 16;
  localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4;
  localparam logic [2:0] MTHI = 3'd5, MTLO = 3'd6, MFHI = 3'd7, MFLO = 3'd0;

  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, flush = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        mdu_busy;
  logic [31:0] mdu_hi, mdu_lo;
  logic [2:0]  mdu_op;
  logic        mdu_start, stall, ctrl_busy, timeout_err;
  logic [31:0] mdu_d1, mdu_d2, rd_data;
`ifdef MDU_DIV0_GUARD_EN
  logic        div0_flag;
`endif

  mdu_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data), .mdu_busy(mdu_busy), .mdu_hi(mdu_hi),
    .mdu_lo(mdu_lo), .mdu_op(mdu_op), .mdu_start(mdu_start), .mdu_d1(mdu_d1),
    .mdu_d2(mdu_d2), .stall(stall), .rd_data(rd_data), .ctrl_busy(ctrl_busy),
`ifdef MDU_DIV0_GUARD_EN
    .div0_flag(div0_flag),
`endif
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // {hi,lo} after an MDU operation, from the architectural definition.
  function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] hi,
                                       input logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MULT:  return sa * sb;
      MULTU: return ua * ub;
      DIV: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      DIVU: begin
        if (b == 32'd0) return {hi, lo};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // Behavioural MDU: Busy rises the cycle after Start and stays high for lat cycles.
  logic        mdu_rst = 1'b1, stuck = 1'b0;
  int          pending_lat = 1, m_cnt;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  always @(posedge clk) begin
    if (mdu_rst) begin
      mdu_busy <= 1'b0; m_cnt <= 0; mdu_hi <= '0; mdu_lo <= '0;
    end else begin
      if (mdu_op == MTHI) mdu_hi <= mdu_d1;
      if (mdu_op == MTLO) mdu_lo <= mdu_d2;
      if (mdu_start) begin
        mdu_busy <= 1'b1; m_cnt <= pending_lat; m_op <= mdu_op; m_a <= mdu_d1; m_b <= mdu_d2;
      end else if (mdu_busy && !stuck) begin
        if (m_cnt == 1) begin
          mdu_busy <= 1'b0;
          {mdu_hi, mdu_lo} <= calc(m_op, m_a, m_b, mdu_hi, mdu_lo);
        end else m_cnt <= m_cnt - 1;
      end
    end
  end

  // Reference model state.
  typedef struct {
    int acc; logic [2:0] op; logic start; logic [31:0] d1, d2, rd;
  } exp_t;
  typedef struct { int from; int to; } win_t;
  exp_t        sb[$];
  win_t        win_q[$];
  logic [31:0] arch_hi = '0, arch_lo = '0;
  int          free_cyc = 0, terr_from = 32'h7fffffff, div0_from = 32'h7fffffff;
  logic        mon_en = 1'b0;

  task automatic send(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input int lat);
    exp_t e;
    win_t w;
    logic muldiv, blocked, ok;
    muldiv  = op inside {MULT, MULTU, DIV, DIVU};
    blocked = 1'b0;
`ifdef MDU_DIV0_GUARD_EN
    blocked = (op inside {DIV, DIVU}) && (rt == 32'd0);
`endif
    e.acc   = (cyc > free_cyc) ? cyc : free_cyc;
    e.start = muldiv && !blocked;
    e.op    = (e.start || op inside {MTHI, MTLO}) ? op : NONE;
    e.d1    = rs;
    e.d2    = (op == MTLO) ? rs : rt;
    e.rd    = (op == MFHI) ? arch_hi : (op == MFLO) ? arch_lo : 32'd0;
    if (op == MTHI) arch_hi = rs;
    if (op == MTLO) arch_lo = rs;
    if (blocked && div0_from > e.acc + 1) div0_from = e.acc + 1;
    if (e.start) begin
      if (stuck) begin
        free_cyc  = e.acc + TO + 1;
        terr_from = free_cyc;
      end else begin
        free_cyc = e.acc + ((lat + 2 > 3) ? lat + 2 : 3);
        {arch_hi, arch_lo} = calc(op, rs, rt, arch_hi, arch_lo);
      end
      pending_lat = lat;
      w.from = e.acc; w.to = free_cyc;
      win_q.push_back(w);
    end
    sb.push_back(e);
    req_valid = 1'b1; flush = 1'b0; req_op = op; rs_data = rs; rt_data = rt;
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = !stall;
    end
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: op %0d still stalled after 64 cycles", op);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic kill(input logic [2:0] op);
    req_valid = 1'b1; flush = 1'b1; req_op = op;
    rs_data = $urandom; rt_data = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT accepts an instruction.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      logic eb;
      if (req_valid && !flush && !stall) begin
        if (sb.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          e = sb.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(e.acc));
          chk("mdu_op", mdu_op, e.op);
          chk("mdu_start", mdu_start, e.start);
          chk("mdu_d1", mdu_d1, e.d1);
          chk("mdu_d2", mdu_d2, e.d2);
          chk("rd_data", rd_data, e.rd);
        end
      end else begin
        chk("idle_op", mdu_op, NONE);
        chk("idle_start", mdu_start, 0);
        if (!req_valid || flush) chk("no_stall", stall, 0);
        if (!req_valid) chk("idle_rd", rd_data, 0);
      end
      while (win_q.size() > 0 && win_q[0].to <= cyc) void'(win_q.pop_front());
      eb = (win_q.size() > 0) && (cyc > win_q[0].from) && (cyc < win_q[0].to);
      chk("ctrl_busy", ctrl_busy, eb);
      chk("timeout_err", timeout_err, cyc >= terr_from);
`ifdef MDU_DIV0_GUARD_EN
      chk("div0_flag", div0_flag, cyc >= div0_from);
`endif
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] rt;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; mdu_rst = 1'b0;
    @(negedge clk);
    chk("rst_op", mdu_op, NONE);
    chk("rst_start", mdu_start, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_busy", ctrl_busy, 0);
    chk("rst_terr", timeout_err, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    send(MULT, 7, 6, 4);     send(MFHI, 0, 0, 1);   send(MFLO, 0, 0, 1);
    send(DIV, -32'sd7, 2, 6); send(MFLO, 0, 0, 1);  send(MFHI, 0, 0, 1);
    send(DIV, 100, 7, 5);    send(DIV, -32'sd9, 4, 2); send(MFLO, 0, 0, 1);
    send(MTLO, 32'h1234, 32'hdead, 1); send(MFLO, 0, 0, 1);
    send(MTHI, 32'h55aa, 0, 1); send(MFHI, 0, 0, 1);
    send(DIVU, 5, 0, 3);     send(MFLO, 0, 0, 1);
    kill(MULT);              send(MFHI, 0, 0, 1);

    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 2) == 0) kill(3'($urandom_range(0, 7)));
        else begin @(posedge clk); #1; end
      end
      send(op, $urandom, rt, $urandom_range(1, 10));
    end

    // Watchdog: Busy never falls.
    repeat (15) @(posedge clk);
    #1; stuck = 1'b1;
    send(MULTU, 3, 5, 4);
    repeat (TO + 4) @(posedge clk);
    #1; mon_en = 1'b0;
    chk("sb_drained", sb.size(), 0);

    // Reset mid-operation returns to idle even with Busy high.
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wd_busy", ctrl_busy, 0);
    chk("rst_wd_terr", timeout_err, 0);
    chk("rst_mdu_busy_high", mdu_busy, 1);
    #1; reset = 1'b0; mdu_rst = 1'b1;
    @(posedge clk); #1;
    mdu_rst = 1'b0; stuck = 1'b0;
    free_cyc = 0; terr_from = 32'h7fffffff; div0_from = 32'h7fffffff; win_q.delete();
    mon_en = 1'b1;
    send(MULT, 9, 9, 8);
    mon_en = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midop_busy", ctrl_busy, 0);
    chk("midop_mdu_busy", mdu_busy, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

endmodule
